arbiter_puf_array: RTL and testbench
====================================

ARBITER_PUF_ARRAY -- requirements
Module: arbiter_puf_array

Interface
REQ-001 Parameter C_LENGTH, default 8, SHALL set the mux-pair stages per delay chain and the challenge width.
REQ-002 Parameter N_CHAINS, default 8, SHALL set the number of independent arbiter chains and response bits.
REQ-003 Parameter N_VOTES, default 5, SHALL set evaluations per challenge; legal: odd, 1..15.
REQ-004 Parameter SETTLE_CYC, default 4, SHALL set the pulse-high and pulse-low hold lengths in clocks; legal: >=2.
REQ-005 clk  in  1  SHALL be the single clock; all block registers except the arbiter sampling flops are clocked on its rising edge.
REQ-006 rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-007 req_valid  in  1  SHALL indicate a challenge request.
REQ-008 req_ready  out  1  SHALL indicate that the block accepts a request.
REQ-009 req_challenge  in  C_LENGTH  SHALL carry the challenge.
REQ-010 test_en  in  1  SHALL select test mode; it is sampled at request accept.
REQ-011 test_raw  in  N_CHAINS  SHALL provide the substitute raw arbiter bits in test mode.
REQ-012 resp_valid  out  1  SHALL indicate that a response is available.
REQ-013 resp_ready  in  1  SHALL indicate that the consumer takes the response.
REQ-014 resp_data  out  N_CHAINS  SHALL carry the majority-voted response.
REQ-015 resp_stable  out  N_CHAINS  SHALL flag bits that were unanimous across all votes.
REQ-016 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-017 Each chain k SHALL be a C_LENGTH-stage crossed mux-pair delay line.
  - Both chain inputs are driven by the internal launch pulse.
  - Stage i crosses its two paths when its select bit is 1.
  - Chain k's select vector is the latched challenge rotated left by k mod C_LENGTH.
REQ-018 Each chain SHALL end in an arbiter flop: D = path-2 output, clock = path-1 output.
  - The flop output passes through a 2-flop synchroniser on clk before use.
REQ-019 Request handshake: accept occurs when req_valid and req_ready are both high.
  - req_ready = (state == IDLE).
  - At accept, req_challenge and test_en are latched and vote counters cleared.
REQ-020 FSM states: IDLE, LAUNCH, SETTLE, SAMPLE, RELAX, DONE.
  - IDLE -> LAUNCH on accept.
  - LAUNCH (1 cycle, pulse rises) -> SETTLE.
  - SETTLE (SETTLE_CYC cycles, pulse high) -> SAMPLE.
  - SAMPLE (1 cycle, pulse high) -> RELAX.
  - RELAX (SETTLE_CYC cycles, pulse low) -> LAUNCH if votes done < N_VOTES, else DONE.
  - DONE -> IDLE on resp_ready.
REQ-021 In SAMPLE, per-chain counter k SHALL increment when its raw bit is 1.
  - Raw bit = synchronised arbiter bit if the latched test_en = 0, else test_raw[k].
  - Counter width = clog2(N_VOTES+1); counters cannot overflow.
REQ-022 Latency: with accept in cycle T, resp_valid SHALL first be high in cycle T+1+N_VOTES*(2*SETTLE_CYC+2).
  - Defaults: T+51.
REQ-023 On entry to DONE, per chain:
  - resp_data[k] = (count_k > N_VOTES/2).
  - resp_stable[k] = (count_k == 0 or count_k == N_VOTES).
REQ-024 Response handshake and holding:
  - resp_valid = (state == DONE).
  - resp_data and resp_stable stay stable while resp_valid is high and resp_ready is low.
  - Both hold their last values after the handshake until the next DONE entry.
REQ-025 req_challenge, test_en and req_valid changes SHALL be ignored while busy.
REQ-026 On the resp_valid/resp_ready handshake cycle, the FSM SHALL go to IDLE; req_ready rises the next cycle, with no same-cycle re-accept.
REQ-027 The launch pulse SHALL be registered and glitch-free, low in IDLE and DONE.

Reset
REQ-028 While rst is high at a clk edge, the block SHALL reset to:
  - state IDLE, pulse 0;
  - counters, vote count and synchronisers 0;
  - resp_valid 0, resp_data 0, resp_stable 0, busy 0;
  - req_ready 1 in the cycle after reset deasserts.
REQ-029 Reset mid-operation SHALL abort the evaluation with no resp_valid pulse; the next accepted request SHALL complete normally.
REQ-030 Arbiter sampling flops SHALL NOT be reset, since their value before the first SAMPLE is unused.

Verification
REQ-031 Reset, all inputs 0 -> after release: req_ready=1, resp_valid=0, resp_data=8'h00, resp_stable=8'h00, busy=0.
REQ-032 Defaults, test_en=1, test_raw=8'hA5 constant, challenge 8'h3C accepted at T -> resp_valid rises at T+51; resp_data=8'hA5, resp_stable=8'hFF.
REQ-033 test_en=1, test_raw per SAMPLE = A5, A5, 5A, 5A, A5 -> resp_data=8'hA5, resp_stable=8'h00.
REQ-034 resp_ready held low 10 cycles after resp_valid, with req_valid=1 and challenge toggling -> resp_valid and resp_data held; req_ready=0 throughout; no second accept.
REQ-035 rst pulsed one cycle during the third vote's SETTLE -> IDLE next cycle; resp_valid never rises; a fresh request with test_raw=8'h0F yields resp_data=8'h0F at accept+51.
REQ-036 N_VOTES=1, SETTLE_CYC=2, test_raw=8'h81 -> resp_valid at T+7; resp_data=8'h81, resp_stable=8'hFF.

Source files
------------

// File: rtl/arbiter_puf_array.sv
// Array of arbiter PUF chains with majority voting over repeated evaluations.
// Each chain races a launch pulse through a crossed mux-pair delay line. An
// arbiter flop decides which path arrived first. The result passes through a
// synchroniser, and per-chain counters accumulate the votes.
module arbiter_puf_array #(
    parameter int C_LENGTH   = 8,
    parameter int N_CHAINS   = 8,
    parameter int N_VOTES    = 5,
    parameter int SETTLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [C_LENGTH-1:0] req_challenge,
    input  logic                test_en,
    input  logic [N_CHAINS-1:0] test_raw,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [N_CHAINS-1:0] resp_data,
    output logic [N_CHAINS-1:0] resp_stable,
    output logic                busy
);

    localparam int CW = $clog2(N_VOTES + 1);
    localparam int SW = $clog2(SETTLE_CYC);
    localparam logic [CW-1:0] VOTES_ALL  = CW'(N_VOTES);
    localparam logic [CW-1:0] VOTES_HALF = CW'(N_VOTES / 2);
    localparam logic [SW-1:0] TMR_LAST   = SW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_SETTLE, S_SAMPLE, S_RELAX, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  pulse_q, pulse_d;
    logic [SW-1:0]         tmr_q, tmr_d;
    logic [CW-1:0]         votes_q, votes_d;
    logic [C_LENGTH-1:0]   chal_q, chal_d;
    logic                  test_q, test_d;
    logic [CW-1:0]         cnt_q [N_CHAINS];
    logic [CW-1:0]         cnt_d [N_CHAINS];
    logic [N_CHAINS-1:0]   data_q, data_d;
    logic [N_CHAINS-1:0]   stable_q, stable_d;
    logic [N_CHAINS-1:0]   sync1_q, sync1_d;
    logic [N_CHAINS-1:0]   sync2_q, sync2_d;
    logic [N_CHAINS-1:0]   arb_raw;
    logic [N_CHAINS-1:0]   raw_bits;
    logic [2*C_LENGTH-1:0] chal_dbl;

    assign chal_dbl = {chal_q, chal_q};

    // Delay chains. Each chain's select vector is the challenge rotated left by the chain index.
    for (genvar gi = 0; gi < N_CHAINS; gi++) begin : g_chain
        localparam int ROT = gi % C_LENGTH;
        logic [C_LENGTH-1:0] sel;
        logic [C_LENGTH:0]   path1;
        logic [C_LENGTH:0]   path2;
        logic                arb_q;

        assign sel      = chal_dbl[2*C_LENGTH-1-ROT -: C_LENGTH];
        assign path1[0] = pulse_q;
        assign path2[0] = pulse_q;

        for (genvar gj = 0; gj < C_LENGTH; gj++) begin : g_stage
            assign path1[gj+1] = sel[gj] ? path2[gj] : path1[gj];
            assign path2[gj+1] = sel[gj] ? path1[gj] : path2[gj];
        end

        // Arbiter flop: path 1 clocks it, path 2 is the data. It has no reset because its value is only used after a launch.
        always_ff @(posedge path1[C_LENGTH]) begin
            arb_q <= path2[C_LENGTH];
        end

        assign arb_raw[gi] = arb_q;
    end

    assign raw_bits    = test_q ? test_raw : sync2_q;
    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign resp_data   = data_q;
    assign resp_stable = stable_q;

    // Next-state logic for the sequencer, vote counters and response latches.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        votes_d  = votes_q;
        chal_d   = chal_q;
        test_d   = test_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        stable_d = stable_q;
        sync1_d  = arb_raw;
        sync2_d  = sync1_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_LAUNCH;
                    chal_d  = req_challenge;
                    test_d  = test_en;
                    votes_d = '0;
                    for (int k = 0; k < N_CHAINS; k++) cnt_d[k] = '0;
                end
            end
            S_LAUNCH: begin
                state_d = S_SETTLE;
                tmr_d   = '0;
            end
            S_SETTLE: begin
                if (tmr_q == TMR_LAST) state_d = S_SAMPLE;
                else                   tmr_d   = tmr_q + 1'b1;
            end
            S_SAMPLE: begin
                state_d = S_RELAX;
                tmr_d   = '0;
                votes_d = votes_q + 1'b1;
                for (int k = 0; k < N_CHAINS; k++) cnt_d[k] = cnt_q[k] + CW'(raw_bits[k]);
            end
            S_RELAX: begin
                if (tmr_q == TMR_LAST) begin
                    if (votes_q < VOTES_ALL) begin
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_DONE;
                        for (int k = 0; k < N_CHAINS; k++) begin
                            data_d[k]   = (cnt_q[k] > VOTES_HALF);
                            stable_d[k] = (cnt_q[k] == '0) || (cnt_q[k] == VOTES_ALL);
                        end
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_DONE: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // The pulse is high from LAUNCH through SAMPLE. It comes from a flop, so it cannot glitch.
        pulse_d = (state_d == S_LAUNCH) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pulse_q  <= 1'b0;
            tmr_q    <= '0;
            votes_q  <= '0;
            chal_q   <= '0;
            test_q   <= 1'b0;
            for (int k = 0; k < N_CHAINS; k++) cnt_q[k] <= '0;
            data_q   <= '0;
            stable_q <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            tmr_q    <= tmr_d;
            votes_q  <= votes_d;
            chal_q   <= chal_d;
            test_q   <= test_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            stable_q <= stable_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
        end
    end

endmodule

// File: tb/tb_arbiter_puf_array.sv
// Bench for arbiter_puf_array: a per-cycle reference model plus directed vectors.
module tb_arbiter_puf_array;

    localparam int NV   = 5;
    localparam int SC   = 4;
    localparam int PER  = 2 * SC + 2;
    localparam int LAT  = 1 + NV * PER;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, test_en, resp_valid, resp_ready, busy;
    logic [7:0] req_challenge, test_raw, resp_data, resp_stable;
    logic       req_valid2, req_ready2, resp_valid2, resp_ready2, busy2;
    logic [7:0] test_raw2, resp_data2, resp_stable2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arbiter_puf_array #(.C_LENGTH(8), .N_CHAINS(8), .N_VOTES(NV), .SETTLE_CYC(SC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_challenge(req_challenge), .test_en(test_en), .test_raw(test_raw),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_stable(resp_stable), .busy(busy)
    );

    arbiter_puf_array #(.C_LENGTH(8), .N_CHAINS(8), .N_VOTES(1), .SETTLE_CYC(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_challenge(req_challenge), .test_en(test_en), .test_raw(test_raw2),
        .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_data(resp_data2),
        .resp_stable(resp_stable2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model. It tracks the cycles elapsed since accept and sums test_raw at each sample slot.
    logic       m_on = 1'b0;
    logic       m_busy, m_done, m_test;
    int         m_t;
    int         m_cnt [8];
    logic [7:0] m_data, m_stable;

    always @(negedge clk) begin
        if (m_on) begin
            chk("cyc_req_ready", req_ready, !m_busy);
            chk("cyc_busy", busy, m_busy);
            chk("cyc_resp_valid", resp_valid, m_done);
            chk("cyc_resp_data", resp_data, m_data);
            chk("cyc_resp_stable", resp_stable, m_stable);
        end
        if (rst) begin
            m_on = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_data = '0; m_stable = '0;
        end else if (m_on) begin
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1'b1; m_done = 1'b0; m_t = 1; m_test = test_en;
                    for (int k = 0; k < 8; k++) m_cnt[k] = 0;
                end
            end else if (m_done) begin
                if (resp_ready) begin m_busy = 1'b0; m_done = 1'b0; end
            end else begin
                if (((m_t - 1) % PER) == 1 + SC && m_test)
                    for (int k = 0; k < 8; k++) m_cnt[k] += int'(test_raw[k]);
                m_t++;
                if (m_t == LAT) begin
                    m_done = 1'b1;
                    for (int k = 0; k < 8; k++) begin
                        m_data[k]   = (m_cnt[k] > NV / 2);
                        m_stable[k] = (m_cnt[k] == 0) || (m_cnt[k] == NV);
                    end
                end
            end
        end
    end

    logic [7:0] pats [5];
    int         t0, lat;
    logic       seen;

    task automatic wait_valid(input int ts, output int l);
        for (int i = 0; i < 200; i++) begin
            if (resp_valid) break;
            tick();
        end
        l = resp_valid ? (cyc - ts) : -1;
    endtask

    initial begin
        pats = '{8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'hA5};
        rst = 1'b1; req_valid = 0; resp_ready = 0; req_challenge = '0; test_en = 0; test_raw = '0;
        req_valid2 = 0; resp_ready2 = 0; test_raw2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 8'h00);
        chk("rst_resp_stable", resp_stable, 8'h00);
        chk("rst_busy", busy, 0);
        $display("reset checked");

        // Constant raw bits.
        test_en = 1; test_raw = 8'hA5; req_challenge = 8'h3C; req_valid = 1;
        tick(); t0 = cyc - 1; req_valid = 0;
        wait_valid(t0, lat);
        chk("const_latency", lat, 51);
        chk("const_data", resp_data, 8'hA5);
        chk("const_stable", resp_stable, 8'hFF);
        $display("constant A5: latency=%0d data=%h stable=%h", lat, resp_data, resp_stable);
        resp_ready = 1; tick(); resp_ready = 0;
        chk("hs_req_ready", req_ready, 1);
        chk("hs_data_hold", resp_data, 8'hA5);

        // Raw bits change from one vote to the next.
        test_raw = pats[0]; req_valid = 1;
        tick(); t0 = cyc - 1; req_valid = 0;
        for (int v = 0; v < NV; v++) begin
            test_raw = pats[v];
            repeat (PER) tick();
        end
        chk("vote_valid", resp_valid, 1);
        chk("vote_data", resp_data, 8'hA5);
        chk("vote_stable", resp_stable, 8'h00);
        $display("voted pattern: data=%h stable=%h", resp_data, resp_stable);

        // Hold the response under back-pressure while requests keep arriving.
        req_valid = 1;
        for (int i = 0; i < 10; i++) begin
            req_challenge = 8'(i * 37 + 1);
            tick();
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", resp_data, 8'hA5);
            chk("hold_req_ready", req_ready, 0);
        end
        $display("backpressure hold: valid=%b data=%h", resp_valid, resp_data);
        resp_ready = 1; tick(); resp_ready = 0; req_valid = 0;
        chk("post_hs_ready", req_ready, 1);
        tick();
        chk("post_hs_idle", busy, 0);

        // Abort with a mid-evaluation reset during the third vote's SETTLE phase.
        test_raw = 8'hF0; req_valid = 1;
        tick(); t0 = cyc - 1; req_valid = 0;
        for (int i = 0; i < 40 && cyc < t0 + 23; i++) tick();
        rst = 1; tick(); rst = 0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", req_ready, 1);
        seen = 0;
        repeat (60) begin tick(); if (resp_valid) seen = 1; end
        chk("abort_no_valid", seen, 0);
        test_raw = 8'h0F; req_valid = 1;
        tick(); t0 = cyc - 1; req_valid = 0;
        wait_valid(t0, lat);
        chk("abort_next_latency", lat, 51);
        chk("abort_next_data", resp_data, 8'h0F);
        $display("after abort: latency=%0d data=%h", lat, resp_data);
        resp_ready = 1; tick(); resp_ready = 0;

        // Single-vote instance with a short settle time.
        test_raw2 = 8'h81; req_valid2 = 1;
        tick(); t0 = cyc - 1; req_valid2 = 0;
        for (int i = 0; i < 50; i++) begin
            if (resp_valid2) break;
            tick();
        end
        lat = resp_valid2 ? (cyc - t0) : -1;
        chk("small_latency", lat, 7);
        chk("small_data", resp_data2, 8'h81);
        chk("small_stable", resp_stable2, 8'hFF);
        $display("small instance: latency=%0d data=%h stable=%h", lat, resp_data2, resp_stable2);
        resp_ready2 = 1; tick(); resp_ready2 = 0;
        chk("small_idle", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
